// File: rtl/matrix_controller_pkg.sv
// matrix_controller_pkg: AXI response codes, write/read FSM states and byte-strobe merge
package matrix_controller_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_A, WR_HAVE_D, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b+:8] = strb[b] ? data[8*b+:8] : old[8*b+:8];
    return res;
  endfunction
endpackage

// File: rtl/matrix_controller_regfile.sv
// matrix_controller_regfile: byte-strobed register bank with write pulses and an async read port
module matrix_controller_regfile
  import matrix_controller_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   i_we,
  input  logic [IDX_W-1:0]       i_widx,
  input  logic [31:0]            i_wdata,
  input  logic [3:0]             i_wstrb,
  input  logic [IDX_W-1:0]       i_ridx,
  output logic [31:0]            o_rdata,
  output logic                   o_rok,
  output logic [NUM_REGS*32-1:0] o_reg_q,
  output logic [NUM_REGS-1:0]    o_reg_wr
);
  logic [NUM_REGS-1:0][31:0] r_q;
  logic [NUM_REGS-1:0]       r_wr;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_q  <= '0;
      r_wr <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_wr[i] <= i_we && i_widx == IDX_W'(i);
        if (i_we && i_widx == IDX_W'(i)) r_q[i] <= apply_wstrb(r_q[i], i_wdata, i_wstrb);
      end
    end
  end
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) if (i_ridx == IDX_W'(i)) o_rdata = r_q[i];
  end
  assign o_rok    = 32'(i_ridx) < NUM_REGS;
  assign o_reg_q  = r_q;
  assign o_reg_wr = r_wr;
endmodule

// File: rtl/matrix_controller_s_axi_regs.sv
// matrix_controller_s_axi_regs: AXI4-Lite responder with independent write/read FSMs over the register bank
module matrix_controller_s_axi_regs
  import matrix_controller_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [NUM_REGS*32-1:0]  reg_q,
  output logic [NUM_REGS-1:0]     reg_wr
);
  localparam int IDX_W = ADDR_WIDTH - 2;
  wr_state_t        r_wst;
  rd_state_t        r_rst;
  logic             r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]       r_bresp, r_rresp;
  logic [31:0]      r_rdata, r_wdata;
  logic [3:0]       r_wstrb;
  logic [IDX_W-1:0] r_awidx;
  logic             w_aw_hs, w_w_hs, w_we, w_wok, w_rok, w_unused;
  logic [IDX_W-1:0] w_aw_idx, w_widx, w_ridx;
  logic [31:0]      w_wdata, w_rdata;
  logic [3:0]       w_wstrb;
  assign w_aw_hs  = AWVALID && r_awready;
  assign w_w_hs   = WVALID && r_wready;
  assign w_aw_idx = AWADDR[ADDR_WIDTH-1:2];
  assign w_ridx   = ARADDR[ADDR_WIDTH-1:2];
  assign w_unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};
  always_comb begin
    w_we    = (w_aw_hs || r_wst == WR_HAVE_A) && (w_w_hs || r_wst == WR_HAVE_D);
    w_widx  = r_wst == WR_HAVE_A ? r_awidx : w_aw_idx;
    w_wdata = r_wst == WR_HAVE_D ? r_wdata : WDATA;
    w_wstrb = r_wst == WR_HAVE_D ? r_wstrb : WSTRB;
    w_wok   = 32'(w_widx) < NUM_REGS;
  end
  matrix_controller_regfile #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_regfile (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .i_we     (w_we),
    .i_widx   (w_widx),
    .i_wdata  (w_wdata),
    .i_wstrb  (w_wstrb),
    .i_ridx   (w_ridx),
    .o_rdata  (w_rdata),
    .o_rok    (w_rok),
    .o_reg_q  (reg_q),
    .o_reg_wr (reg_wr)
  );
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wst     <= WR_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
      r_awidx   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_we) begin
      r_wst     <= WR_RESP;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end else if (r_wst == WR_RESP) begin
      if (BREADY) begin
        r_wst     <= WR_IDLE;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
        r_bvalid  <= 1'b0;
      end
    end else if (w_aw_hs) begin
      r_wst     <= WR_HAVE_A;
      r_awidx   <= w_aw_idx;
      r_awready <= 1'b0;
      r_wready  <= 1'b1;
    end else if (w_w_hs) begin
      r_wst     <= WR_HAVE_D;
      r_wdata   <= WDATA;
      r_wstrb   <= WSTRB;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
    end else if (r_wst == WR_IDLE) begin
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
    end
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rst     <= RD_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= AXI_RESP_OKAY;
    end else if (r_rst == RD_RESP) begin
      if (RREADY) begin
        r_rst     <= RD_IDLE;
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
      end
    end else if (ARVALID && r_arready) begin
      r_rst     <= RD_RESP;
      r_rvalid  <= 1'b1;
      r_arready <= 1'b0;
      r_rdata   <= w_rdata;
      r_rresp   <= w_rok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end else begin
      r_arready <= 1'b1;
    end
  end
  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;
endmodule
